qvalue_scheduler: RTL and testbench
===================================

QVALUE_SCHEDULER -- requirements
Module: qvalue_scheduler

Interface
REQ-001 Parameter WORD_WIDTH, default 16: width of energy, hop and Q-value words.
REQ-002 Parameter MAX_NEIGHBORS, default 16: neighbor table depth; index width NIDX = clog2(MAX_NEIGHBORS).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port list:
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  request one full evaluation round.
- neighbor_count  in  NIDX+1  valid table entries, values above MAX_NEIGHBORS clamp to MAX_NEIGHBORS.
- myEnergy  in  WORD_WIDTH  own residual energy.
- hopsFromSink  in  WORD_WIDTH  own hop count.
- tbl_rd_en  out  1  table read strobe.
- tbl_addr  out  NIDX  table read index.
- tbl_energy  in  WORD_WIDTH  entry energy, valid the cycle after tbl_rd_en.
- tbl_hops  in  WORD_WIDTH  entry hops, valid the cycle after tbl_rd_en.
- qc_energy, qc_hops, qc_min, qc_max  out  WORD_WIDTH each  registered operands to the combinational Q-value datapath.
- qc_qvalue  in  WORD_WIDTH  datapath result, combinational on qc_* operands.
- busy  out  1  round in progress.
- done  out  1  one-cycle completion pulse.
- my_qvalue  out  WORD_WIDTH  own Q-value.
- best_valid  out  1  best_idx/best_qvalue meaningful.
- best_idx  out  NIDX  index of highest-Q neighbor.
- best_qvalue  out  WORD_WIDTH  Q-value of best_idx.

Function
REQ-005 FSM states: IDLE, SCAN, SELF, EVAL, DONE. IDLE->SCAN on start when N>=1, IDLE->SELF on start when N=0, SCAN->SELF, SELF->EVAL when N>=1, SELF->DONE when N=0, EVAL->DONE, DONE->IDLE.
REQ-006 start SHALL be sampled only in IDLE. start while busy SHALL be ignored. N and own inputs SHALL be latched on acceptance.
REQ-007 SCAN: issue reads at addr 0..N-1, one per cycle, then 1 drain cycle (N+1 cycles). min/max SHALL initialise to latched myEnergy and update with each returned tbl_energy using an unsigned compare.
REQ-008 SELF (2 cycles): cycle 1 registers qc_energy=myEnergy, qc_hops=hopsFromSink, qc_min/qc_max=tracked range. Cycle 2 captures qc_qvalue into my_qvalue.
REQ-009 EVAL: reissue reads 0..N-1, one per cycle. Returned data is registered onto qc_energy/qc_hops the next cycle, and qc_qvalue is sampled the cycle after that (N+2 cycles). qc_min/qc_max SHALL hold constant throughout EVAL.
REQ-010 Best selection: the first sampled entry always loads best. Later entries replace it only if strictly greater (unsigned). On ties the lower index is kept.
REQ-011 DONE: done=1 for exactly one cycle, busy=0. best_valid=1 iff N>=1. Results hold until the next accepted start.
REQ-012 Latency from the start-acceptance edge to done high: 2N+6 cycles for N>=1, 3 cycles for N=0.
REQ-013 busy=1 in SCAN, SELF and EVAL. tbl_rd_en SHALL be high only on read-issue cycles. tbl_addr SHALL be 0 when not reading.
REQ-014 On acceptance of a new start, best_valid SHALL clear. my_qvalue and best_* SHALL keep their old values until overwritten.

Reset
REQ-015 nrst low SHALL immediately force IDLE and clear to 0: busy, done, tbl_rd_en, tbl_addr, qc_*, my_qvalue, best_valid, best_idx, best_qvalue, min/max.
REQ-016 Reset mid-round SHALL abort the round with no done pulse. The first start after release SHALL begin a clean round.

Structure
REQ-017 Package eerrl_pkg SHALL hold WORD_WIDTH, MAX_NEIGHBORS and the FSM state enum.
REQ-018 Min/max tracking SHALL be one sub-module, energy_range_tracker (init, update, min, max). The Q-value datapath stays external.

Verification (stub qc_qvalue = qc_energy)
REQ-019 N=3, energies {0x3000,0x9000,0x5000}, myEnergy=0x8000 -> qc_min=0x3000, qc_max=0x9000, best_idx=1, best_qvalue=0x9000, done 12 cycles after start.
REQ-020 N=0, myEnergy=0x8000 -> no tbl_rd_en, my_qvalue=0x8000, best_valid=0, done 3 cycles after start.
REQ-021 N=2 with equal energies 0x4000 -> best_idx=0.
REQ-022 start pulsed again during EVAL -> ignored, single done, results unchanged from the single-round case.
REQ-023 nrst asserted mid-SCAN -> all outputs 0 at once, no done. A later round gives correct results.
REQ-024 neighbor_count=31 with MAX_NEIGHBORS=16 -> exactly 16 reads per pass, done 38 cycles after start.

Source files
------------

// File: rtl/eerrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eerrl_pkg : shared sizing constants and scheduler FSM state encoding        |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
package eerrl_pkg;

  localparam int WORD_WIDTH    = 16;
  localparam int MAX_NEIGHBORS = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_SELF = 3'd2,
    ST_EVAL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/energy_range_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | energy_range_tracker : running unsigned min/max of neighbor energies        |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module energy_range_tracker #(
  parameter int WIDTH = eerrl_pkg::WORD_WIDTH
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             init,
  input  logic [WIDTH-1:0] initEnergy,
  input  logic             update,
  input  logic [WIDTH-1:0] energy,
  output logic [WIDTH-1:0] rangeMin,
  output logic [WIDTH-1:0] rangeMax
);
  import eerrl_pkg::*;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rangeMin <= '0;
      rangeMax <= '0;
    end else if (init) begin
      rangeMin <= initEnergy;
      rangeMax <= initEnergy;
    end else if (update) begin
      if (energy < rangeMin) rangeMin <= energy;
      if (energy > rangeMax) rangeMax <= energy;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qvalue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qvalue_scheduler : scans the neighbor table, computes own Q-value and picks |
// |                    the highest-Q neighbor via an external datapath         |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module qvalue_scheduler #(
  parameter int WORD_WIDTH    = eerrl_pkg::WORD_WIDTH,
  parameter int MAX_NEIGHBORS = eerrl_pkg::MAX_NEIGHBORS,
  localparam int NIDX         = $clog2(MAX_NEIGHBORS)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [NIDX:0]         neighbor_count,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] hopsFromSink,
  output logic                  tbl_rd_en,
  output logic [NIDX-1:0]       tbl_addr,
  input  logic [WORD_WIDTH-1:0] tbl_energy,
  input  logic [WORD_WIDTH-1:0] tbl_hops,
  output logic [WORD_WIDTH-1:0] qc_energy,
  output logic [WORD_WIDTH-1:0] qc_hops,
  output logic [WORD_WIDTH-1:0] qc_min,
  output logic [WORD_WIDTH-1:0] qc_max,
  input  logic [WORD_WIDTH-1:0] qc_qvalue,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] my_qvalue,
  output logic                  best_valid,
  output logic [NIDX-1:0]       best_idx,
  output logic [WORD_WIDTH-1:0] best_qvalue
);
  import eerrl_pkg::*;

  localparam logic [NIDX:0] c_maxN = (NIDX+1)'(MAX_NEIGHBORS);

  state_t                r_state;
  logic [NIDX:0]         r_n;
  logic [WORD_WIDTH-1:0] r_myEnergy;
  logic [WORD_WIDTH-1:0] r_hops;
  logic                  r_selfPhase;
  logic                  r_rdPipe;
  logic [NIDX-1:0]       r_pipeIdx;
  logic                  r_qcValid;
  logic [NIDX-1:0]       r_qcIdx;
  logic                  r_bestLoaded;

  logic [NIDX:0]         w_nClamped;
  logic [NIDX-1:0]       w_lastIdx;
  logic                  w_accept;
  logic [WORD_WIDTH-1:0] w_rangeMin;
  logic [WORD_WIDTH-1:0] w_rangeMax;

  assign w_nClamped = (neighbor_count > c_maxN) ? c_maxN : neighbor_count;
  assign w_lastIdx  = NIDX'(r_n - 1'b1);
  assign w_accept   = (r_state == ST_IDLE) && start;

  // Range only follows table data returned during the first pass.
  energy_range_tracker #(
    .WIDTH(WORD_WIDTH)
  ) u_rangeTracker (
    .clk       (clk),
    .nrst      (nrst),
    .init      (w_accept),
    .initEnergy(myEnergy),
    .update    ((r_state == ST_SCAN) && r_rdPipe),
    .energy    (tbl_energy),
    .rangeMin  (w_rangeMin),
    .rangeMax  (w_rangeMax)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_n          <= '0;
      r_myEnergy   <= '0;
      r_hops       <= '0;
      r_selfPhase  <= 1'b0;
      r_rdPipe     <= 1'b0;
      r_pipeIdx    <= '0;
      r_qcValid    <= 1'b0;
      r_qcIdx      <= '0;
      r_bestLoaded <= 1'b0;
      tbl_rd_en    <= 1'b0;
      tbl_addr     <= '0;
      qc_energy    <= '0;
      qc_hops      <= '0;
      qc_min       <= '0;
      qc_max       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      my_qvalue    <= '0;
      best_valid   <= 1'b0;
      best_idx     <= '0;
      best_qvalue  <= '0;
    end else begin
      r_rdPipe  <= tbl_rd_en;
      r_pipeIdx <= tbl_addr;
      r_qcValid <= 1'b0;
      done      <= 1'b0;

      // Shared read sequencer for both table passes.
      if ((r_state == ST_SCAN || r_state == ST_EVAL) && tbl_rd_en) begin
        if (tbl_addr == w_lastIdx) begin
          tbl_rd_en <= 1'b0;
          tbl_addr  <= '0;
        end else begin
          tbl_addr <= tbl_addr + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_n          <= w_nClamped;
            r_myEnergy   <= myEnergy;
            r_hops       <= hopsFromSink;
            r_selfPhase  <= 1'b0;
            r_bestLoaded <= 1'b0;
            busy         <= 1'b1;
            best_valid   <= 1'b0;
            if (w_nClamped != '0) begin
              r_state   <= ST_SCAN;
              tbl_rd_en <= 1'b1;
              tbl_addr  <= '0;
            end else begin
              r_state <= ST_SELF;
            end
          end
        end
        ST_SCAN: begin
          if (!tbl_rd_en) r_state <= ST_SELF;
        end
        ST_SELF: begin
          if (!r_selfPhase) begin
            qc_energy   <= r_myEnergy;
            qc_hops     <= r_hops;
            qc_min      <= w_rangeMin;
            qc_max      <= w_rangeMax;
            r_selfPhase <= 1'b1;
          end else begin
            my_qvalue   <= qc_qvalue;
            r_selfPhase <= 1'b0;
            if (r_n != '0) begin
              r_state   <= ST_EVAL;
              tbl_rd_en <= 1'b1;
              tbl_addr  <= '0;
            end else begin
              r_state <= ST_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        ST_EVAL: begin
          if (r_rdPipe) begin
            qc_energy <= tbl_energy;
            qc_hops   <= tbl_hops;
            r_qcIdx   <= r_pipeIdx;
            r_qcValid <= 1'b1;
          end
          if (r_qcValid) begin
            if (!r_bestLoaded || (qc_qvalue > best_qvalue)) begin
              best_idx    <= r_qcIdx;
              best_qvalue <= qc_qvalue;
            end
            r_bestLoaded <= 1'b1;
            if (r_qcIdx == w_lastIdx) begin
              r_state    <= ST_DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              best_valid <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qvalue_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qvalue_scheduler : scoreboard bench for qvalue_scheduler, Q stub = energy|
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_qvalue_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [4:0]  neighbor_count;
  logic [15:0] myEnergy, hopsFromSink;
  logic        tbl_rd_en;
  logic [3:0]  tbl_addr;
  logic [15:0] tbl_energy = '0, tbl_hops = '0;
  logic [15:0] qc_energy, qc_hops, qc_min, qc_max, qc_qvalue;
  logic        busy, done, best_valid;
  logic [15:0] my_qvalue, best_qvalue;
  logic [3:0]  best_idx;

  logic [15:0] memE [16];
  logic [15:0] memH [16];

  typedef struct {
    int          acc;
    int          lat;
    int          reads;
    logic [15:0] myq, mn, mx, bq;
    logic        bv;
    logic [3:0]  bi;
  } exp_t;

  exp_t sbq[$];
  int   nTests = 0, nFails = 0;
  int   cyc = 0, doneCount = 0, rdCount = 0;

  qvalue_scheduler dut (
    .clk           (clk),
    .nrst          (nrst),
    .start         (start),
    .neighbor_count(neighbor_count),
    .myEnergy      (myEnergy),
    .hopsFromSink  (hopsFromSink),
    .tbl_rd_en     (tbl_rd_en),
    .tbl_addr      (tbl_addr),
    .tbl_energy    (tbl_energy),
    .tbl_hops      (tbl_hops),
    .qc_energy     (qc_energy),
    .qc_hops       (qc_hops),
    .qc_min        (qc_min),
    .qc_max        (qc_max),
    .qc_qvalue     (qc_qvalue),
    .busy          (busy),
    .done          (done),
    .my_qvalue     (my_qvalue),
    .best_valid    (best_valid),
    .best_idx      (best_idx),
    .best_qvalue   (best_qvalue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign qc_qvalue = qc_energy;

  always @(posedge clk) begin
    if (tbl_rd_en) begin
      tbl_energy <= memE[tbl_addr];
      tbl_hops   <= memH[tbl_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!nrst) begin
      rdCount = 0;
    end else begin
      if (tbl_rd_en) rdCount++;
      else check("addr idle zero", 32'(tbl_addr), 32'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("latency",     32'(cyc - e.acc + 1), 32'(e.lat));
          check("read count",  32'(rdCount), 32'(e.reads));
          check("my_qvalue",   32'(my_qvalue), 32'(e.myq));
          check("qc_min",      32'(qc_min), 32'(e.mn));
          check("qc_max",      32'(qc_max), 32'(e.mx));
          check("best_valid",  32'(best_valid), 32'(e.bv));
          check("best_idx",    32'(best_idx), 32'(e.bi));
          check("best_qvalue", 32'(best_qvalue), 32'(e.bq));
          check("busy at done", 32'(busy), 32'd0);
        end
        rdCount = 0;
        doneCount++;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},        32'(busy), 32'd0);
    check({tag, " done"},        32'(done), 32'd0);
    check({tag, " tbl_rd_en"},   32'(tbl_rd_en), 32'd0);
    check({tag, " tbl_addr"},    32'(tbl_addr), 32'd0);
    check({tag, " qc_energy"},   32'(qc_energy), 32'd0);
    check({tag, " qc_hops"},     32'(qc_hops), 32'd0);
    check({tag, " qc_min"},      32'(qc_min), 32'd0);
    check({tag, " qc_max"},      32'(qc_max), 32'd0);
    check({tag, " my_qvalue"},   32'(my_qvalue), 32'd0);
    check({tag, " best_valid"},  32'(best_valid), 32'd0);
    check({tag, " best_idx"},    32'(best_idx), 32'd0);
    check({tag, " best_qvalue"}, 32'(best_qvalue), 32'd0);
  endtask

  task automatic run_round(input int n, input logic [15:0] myE, input int lat, input int reads,
                           input logic [15:0] myq, input logic [15:0] mn, input logic [15:0] mx,
                           input logic bv, input logic [3:0] bi, input logic [15:0] bq,
                           input int pulseAt);
    exp_t e;
    int   d0;
    @(negedge clk);
    neighbor_count = n[4:0];
    myEnergy       = myE;
    hopsFromSink   = 16'd3;
    start          = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    myEnergy = ~myE;
    e.acc = cyc; e.lat = lat; e.reads = reads; e.myq = myq;
    e.mn = mn; e.mx = mx; e.bv = bv; e.bi = bi; e.bq = bq;
    sbq.push_back(e);
    check("accept busy", 32'(busy), 32'd1);
    check("accept best_valid clear", 32'(best_valid), 32'd0);
    d0 = doneCount;
    for (int i = 1; i <= 200 && doneCount == d0; i++) begin
      @(negedge clk);
      start = (i == pulseAt);
    end
    start = 1'b0;
    if (doneCount == d0) begin
      check("done timeout", 32'd1, 32'd0);
      sbq.delete();
    end
    repeat (30) @(negedge clk);
    check("single done", 32'(doneCount - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    nrst = 1'b0; start = 1'b0; neighbor_count = '0;
    myEnergy = '0; hopsFromSink = '0;
    for (int i = 0; i < 16; i++) begin
      memE[i] = '0;
      memH[i] = 16'(i);
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    nrst = 1'b1;

    // Distinct energies: best is index 1, range spans both sides of own energy
    memE[0] = 16'h3000; memE[1] = 16'h9000; memE[2] = 16'h5000;
    run_round(3, 16'h8000, 12, 6, 16'h8000, 16'h3000, 16'h9000, 1'b1, 4'd1, 16'h9000, 0);

    // No neighbors: best_* keep previous round's values
    run_round(0, 16'h8000, 3, 0, 16'h8000, 16'h8000, 16'h8000, 1'b0, 4'd1, 16'h9000, 0);

    // Tie keeps the lower index
    memE[0] = 16'h4000; memE[1] = 16'h4000;
    run_round(2, 16'h1000, 10, 4, 16'h1000, 16'h1000, 16'h4000, 1'b1, 4'd0, 16'h4000, 0);

    // Start pulsed during EVAL is ignored
    memE[0] = 16'h3000; memE[1] = 16'h9000; memE[2] = 16'h5000;
    run_round(3, 16'h8000, 12, 6, 16'h8000, 16'h3000, 16'h9000, 1'b1, 4'd1, 16'h9000, 8);

    // Reset asserted mid-SCAN aborts the round
    @(negedge clk);
    neighbor_count = 5'd4; myEnergy = 16'h6000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-abort rd_en", 32'(tbl_rd_en), 32'd1);
    nrst = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    d0 = doneCount;
    repeat (30) @(negedge clk);
    check("no done after abort", 32'(doneCount - d0), 32'd0);

    memE[0] = 16'h2000; memE[1] = 16'h7000;
    run_round(2, 16'h1000, 10, 4, 16'h1000, 16'h1000, 16'h7000, 1'b1, 4'd1, 16'h7000, 0);

    // Oversized count clamps to 16 entries; tie between 9 and 12 keeps 9
    for (int i = 0; i < 16; i++) memE[i] = 16'((i + 1) * 256);
    memE[9] = 16'hF000; memE[12] = 16'hF000;
    run_round(31, 16'h0500, 38, 32, 16'h0500, 16'h0100, 16'hF000, 1'b1, 4'd9, 16'hF000, 0);

    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
`default_nettype wire
